// File: rtl/io_oser_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_oser_bank_if
//  Purpose  : Parallel-word handshake between a word source and the
//             io_oser_bank serialiser.
//  Signals  : din        CHANNELS*GEAR  parallel word, channel c at
//                                       [c*GEAR +: GEAR], bit 0 sent first
//             t_in       CHANNELS       per-channel tristate (1 = high-Z)
//             din_valid  1              word present
//             din_ready  1              serialiser can accept a word
//  Modports : master (word source), slave (serialiser)
//  Revision : 1.0 - initial release
// ============================================================================
interface io_oser_bank_if #(
    parameter int CHANNELS = 4,
    parameter int GEAR     = 4
);
    logic [CHANNELS*GEAR-1:0] din;
    logic [CHANNELS-1:0]      t_in;
    logic                     din_valid;
    logic                     din_ready;

    modport master (
        output din,
        output t_in,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  t_in,
        input  din_valid,
        output din_ready
    );
endinterface
`default_nettype wire

// File: rtl/io_oser_bank.sv
`default_nettype none
// ============================================================================
//  Module   : io_oser_bank
//  Purpose  : Bank of CHANNELS output serialisers sharing one shifter/hold
//             pair. Each accepted word is shifted out LSB first, GEAR bits
//             per channel, with back-to-back words streaming gap-free.
//  Ports    : clk         rising-edge clock
//             rst_n       asynchronous active-low reset
//             s_if        word handshake (slave modport)
//             pad_o       registered serial data, one bit per channel
//             pad_t       registered tristate control, one bit per channel
//             busy        shifter holds a word
//             words_sent  count of words fully shifted out (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module io_oser_bank #(
    parameter int CHANNELS = 4,
    parameter int GEAR     = 4,
    parameter bit INIT_T   = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    io_oser_bank_if.slave      s_if,
    output logic [CHANNELS-1:0] pad_o,
    output logic [CHANNELS-1:0] pad_t,
    output logic               busy,
    output logic [15:0]        words_sent
);

    localparam int              c_cnt_w = (GEAR > 1) ? $clog2(GEAR) : 1;
    localparam int              c_w     = CHANNELS * GEAR;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(GEAR - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state,     w_state_n;
    logic [c_cnt_w-1:0]   r_cnt,       w_cnt_n;
    logic [c_w-1:0]       r_sh,        w_sh_n;
    logic [c_w-1:0]       r_hold,      w_hold_n;
    logic [CHANNELS-1:0]  r_hold_t,    w_hold_t_n;
    logic                 r_hold_full, w_hold_full_n;
    logic [CHANNELS-1:0]  r_pad_o,     w_pad_o_n;
    logic [CHANNELS-1:0]  r_pad_t,     w_pad_t_n;
    logic [15:0]          r_words,     w_words_n;

    logic                 w_xfer;
    logic                 w_last;
    logic [c_w-1:0]       w_sh_adv;   // shifter with every lane moved down one bit
    logic [CHANNELS-1:0]  w_din_b0;   // first bit of each lane of the incoming word
    logic [CHANNELS-1:0]  w_hold_b0;  // first bit of each lane of the held word
    logic [CHANNELS-1:0]  w_adv_b0;   // next bit of each lane of the shifting word

    // The shifter is kept so that bit 0 of every lane is the bit on the pad;
    // advancing is a per-lane right shift, which avoids variable indexing.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign w_sh_adv[c*GEAR +: GEAR] = r_sh[c*GEAR +: GEAR] >> 1;
        assign w_din_b0[c]  = s_if.din[c*GEAR];
        assign w_hold_b0[c] = r_hold[c*GEAR];
        assign w_adv_b0[c]  = w_sh_adv[c*GEAR];
    end

    assign s_if.din_ready = ~r_hold_full;
    assign w_xfer         = s_if.din_valid & ~r_hold_full;
    assign w_last         = (r_cnt == c_last);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_sh_n        = r_sh;
        w_hold_n      = r_hold;
        w_hold_t_n    = r_hold_t;
        w_hold_full_n = r_hold_full;
        w_pad_o_n     = r_pad_o;
        w_pad_t_n     = r_pad_t;
        w_words_n     = r_words;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_n = ST_SHIFT;
                    w_sh_n    = s_if.din;
                    w_cnt_n   = '0;
                    w_pad_o_n = w_din_b0;
                    w_pad_t_n = s_if.t_in;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_words_n = r_words + 16'd1;
                    w_cnt_n   = '0;
                    // A full hold always wins; din_ready is low then, so no
                    // incoming word can collide with the move.
                    if (r_hold_full) begin
                        w_sh_n        = r_hold;
                        w_hold_full_n = 1'b0;
                        w_pad_o_n     = w_hold_b0;
                        w_pad_t_n     = r_hold_t;
                    end else if (w_xfer) begin
                        w_sh_n    = s_if.din;
                        w_pad_o_n = w_din_b0;
                        w_pad_t_n = s_if.t_in;
                    end else begin
                        // pad_o keeps the last driven bit while released
                        w_state_n = ST_IDLE;
                        w_pad_t_n = {CHANNELS{INIT_T}};
                    end
                end else begin
                    w_cnt_n   = r_cnt + c_cnt_w'(1);
                    w_sh_n    = w_sh_adv;
                    w_pad_o_n = w_adv_b0;
                    if (w_xfer) begin
                        w_hold_n      = s_if.din;
                        w_hold_t_n    = s_if.t_in;
                        w_hold_full_n = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_hold      <= '0;
            r_hold_t    <= '0;
            r_hold_full <= 1'b0;
            r_pad_o     <= '0;
            r_pad_t     <= {CHANNELS{INIT_T}};
            r_words     <= 16'd0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_sh        <= w_sh_n;
            r_hold      <= w_hold_n;
            r_hold_t    <= w_hold_t_n;
            r_hold_full <= w_hold_full_n;
            r_pad_o     <= w_pad_o_n;
            r_pad_t     <= w_pad_t_n;
            r_words     <= w_words_n;
        end
    end

    assign pad_o      = r_pad_o;
    assign pad_t      = r_pad_t;
    assign busy       = (r_state == ST_SHIFT);
    assign words_sent = r_words;

endmodule
`default_nettype wire

// File: tb/tb_io_oser_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_oser_bank
//  Purpose  : Self-checking bench for io_oser_bank. Two instances: a 4x4
//             serialiser (u_dut4) and a 4x1 serialiser (u_dut1). A word-level
//             queue model predicts pad outputs, readiness and word counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_oser_bank;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    io_oser_bank_if #(.CHANNELS(4), .GEAR(4)) if4 ();
    io_oser_bank_if #(.CHANNELS(4), .GEAR(1)) if1 ();

    logic [3:0]  pad_o4, pad_t4, pad_o1, pad_t1;
    logic        busy4, busy1;
    logic [15:0] ws4, ws1;

    io_oser_bank #(.CHANNELS(4), .GEAR(4), .INIT_T(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_if(if4),
        .pad_o(pad_o4), .pad_t(pad_t4), .busy(busy4), .words_sent(ws4)
    );

    io_oser_bank #(.CHANNELS(4), .GEAR(1), .INIT_T(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_if(if1),
        .pad_o(pad_o1), .pad_t(pad_t1), .busy(busy1), .words_sent(ws1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- word-level reference model ----------------
    // Each DUT is a FIFO of at most two words; the head is being sent,
    // m_idx is the bit of the head currently on the pads.
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  t;
    } word_t;

    word_t       mq0[$];
    word_t       mq1[$];
    int          m_idx [2];
    logic [15:0] m_cnt [2];
    logic [3:0]  m_po  [2];
    logic [3:0]  m_pt  [2];
    bit          m_xfer[2];

    function automatic logic [3:0] lane(input logic [15:0] d, input int g, input int k);
        logic [3:0] b;
        for (int c = 0; c < 4; c++) b[c] = d[c*g + k];
        return b;
    endfunction

    function automatic int m_size(input int id);
        return (id == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic void m_reset();
        mq0.delete();
        mq1.delete();
        for (int i = 0; i < 2; i++) begin
            m_idx[i] = 0; m_cnt[i] = 16'd0; m_po[i] = 4'h0; m_pt[i] = 4'hF; m_xfer[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int id, input logic v,
                                       input logic [15:0] d, input logic [3:0] t);
        word_t q[$];
        int    g;
        bit    xfer;
        word_t w;
        g = (id == 0) ? 4 : 1;
        if (id == 0) q = mq0; else q = mq1;
        xfer = (v === 1'b1) && (q.size() < 2);
        if (q.size() > 0) begin
            if (m_idx[id] == g - 1) begin
                void'(q.pop_front());
                m_cnt[id] = m_cnt[id] + 16'd1;
                m_idx[id] = 0;
            end else begin
                m_idx[id] = m_idx[id] + 1;
            end
        end
        if (xfer) begin
            if (q.size() == 0) m_idx[id] = 0;
            w.d = d;
            w.t = t;
            q.push_back(w);
        end
        if (q.size() > 0) begin
            m_po[id] = lane(q[0].d, g, m_idx[id]);
            m_pt[id] = q[0].t;
        end else begin
            m_pt[id] = 4'hF;
        end
        m_xfer[id] = xfer;
        if (id == 0) mq0 = q; else mq1 = q;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1) begin
            model_step(0, if4.din_valid, if4.din, if4.t_in);
            model_step(1, if1.din_valid, {12'h000, if1.din}, if1.t_in);
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        if4.din = '0; if4.t_in = '0; if4.din_valid = 1'b0;
        if1.din = '0; if1.t_in = '0; if1.din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        n_checks++; if (pad_o4 !== 4'h0) begin n_errors++; $display("FAIL reset_pad_o got=%h exp=0", pad_o4); end
        n_checks++; if (pad_t4 !== 4'hF) begin n_errors++; $display("FAIL reset_pad_t got=%h exp=F", pad_t4); end
        n_checks++; if (busy4 !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy4); end
        n_checks++; if (if4.din_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", if4.din_ready); end
        n_checks++; if (ws4 !== 16'd0) begin n_errors++; $display("FAIL reset_words got=%h exp=0", ws4); end
        n_checks++; if (pad_t1 !== 4'hF || if1.din_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_g1 got pad_t=%h ready=%b exp F/1", pad_t1, if1.din_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // First transfer is attempted on the very first edge after release.
    task automatic test_single();
        logic [3:0] seq;
        seq = 4'b0011;  // ch0 nibble of A5C3, bit 0 first
        if4.din = 16'hA5C3; if4.t_in = 4'h0; if4.din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if4.din_valid = 1'b0;
            n_checks++; if (pad_o4[0] !== seq[i]) begin n_errors++; $display("FAIL single_ch0 cyc=%0d got=%b exp=%b", i+1, pad_o4[0], seq[i]); end
            n_checks++; if (pad_o4 !== m_po[0] || pad_t4 !== 4'h0) begin
                n_errors++; $display("FAIL single_pads cyc=%0d got=%h/%h exp=%h/0", i+1, pad_o4, pad_t4, m_po[0]);
            end
        end
        tick();
        n_checks++; if (busy4 !== 1'b0 || pad_t4 !== 4'hF) begin
            n_errors++; $display("FAIL single_idle got busy=%b pad_t=%h exp 0/F", busy4, pad_t4);
        end
        n_checks++; if (ws4 !== 16'd1) begin n_errors++; $display("FAIL single_words got=%0d exp=1", ws4); end
        n_checks++; if (pad_o4 !== 4'b1010) begin n_errors++; $display("FAIL single_hold_last got=%b exp=1010", pad_o4); end
    endtask

    task automatic test_back_to_back();
        int accepted, busy_cycles, cycles;
        logic [15:0] base;
        base = ws4; accepted = 0; busy_cycles = 0; cycles = 0;
        if4.din = 16'($urandom); if4.t_in = 4'($urandom);
        while (cycles < 40) begin
            if4.din_valid = (accepted < 3);
            tick();
            cycles++;
            if (m_xfer[0]) begin
                accepted++;
                if4.din = 16'($urandom); if4.t_in = 4'($urandom);
            end
            if (busy4 === 1'b1) busy_cycles++;
            n_checks++; if (pad_o4 !== m_po[0] || pad_t4 !== m_pt[0]) begin
                n_errors++; $display("FAIL b2b_pads cyc=%0d got=%h/%h exp=%h/%h", cycles, pad_o4, pad_t4, m_po[0], m_pt[0]);
            end
            n_checks++; if (if4.din_ready !== (m_size(0) < 2)) begin
                n_errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cycles, if4.din_ready, m_size(0) < 2);
            end
            if (accepted == 3 && m_size(0) == 0) break;
        end
        if4.din_valid = 1'b0;
        n_checks++; if (cycles >= 40) begin n_errors++; $display("FAIL b2b_timeout got=%0d cycles exp<40", cycles); end
        n_checks++; if (busy_cycles !== 12) begin n_errors++; $display("FAIL b2b_busy_cycles got=%0d exp=12", busy_cycles); end
        n_checks++; if (ws4 !== base + 16'd3) begin n_errors++; $display("FAIL b2b_words got=%0d exp=%0d", ws4, base + 16'd3); end
    endtask

    task automatic test_gear1();
        logic [15:0] base;
        logic [3:0]  sent;
        int          busy_cycles;
        base = ws1; busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            sent = 4'($urandom);
            if1.din = sent; if1.t_in = 4'($urandom); if1.din_valid = 1'b1;
            tick();
            if (busy1 === 1'b1) busy_cycles++;
            n_checks++; if (pad_o1 !== sent || pad_t1 !== if1.t_in) begin
                n_errors++; $display("FAIL g1_pads i=%0d got=%h/%h exp=%h/%h", i, pad_o1, pad_t1, sent, if1.t_in);
            end
            n_checks++; if (if1.din_ready !== 1'b1) begin n_errors++; $display("FAIL g1_ready i=%0d got=%b exp=1", i, if1.din_ready); end
        end
        if1.din_valid = 1'b0;
        tick();
        if (busy1 === 1'b1) busy_cycles++;
        n_checks++; if (busy_cycles !== 8) begin n_errors++; $display("FAIL g1_busy_cycles got=%0d exp=8", busy_cycles); end
        n_checks++; if (ws1 !== base + 16'd8 || ws1 !== m_cnt[1]) begin
            n_errors++; $display("FAIL g1_words got=%0d exp=%0d", ws1, base + 16'd8);
        end
    endtask

    task automatic test_tristate();
        if4.din = 16'($urandom); if4.t_in = 4'b0101; if4.din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if4.din_valid = 1'b0;
            n_checks++; if (pad_t4 !== 4'b0101 || pad_o4 !== m_po[0]) begin
                n_errors++; $display("FAIL tri_word cyc=%0d got=%b/%h exp=0101/%h", i+1, pad_t4, pad_o4, m_po[0]);
            end
        end
        tick();
        n_checks++; if (pad_t4 !== 4'b1111) begin n_errors++; $display("FAIL tri_idle got=%b exp=1111", pad_t4); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if4.din_valid = (($urandom % 4) != 0);
            if4.din = 16'($urandom); if4.t_in = 4'($urandom);
            tick();
            n_checks++; if (pad_o4 !== m_po[0] || pad_t4 !== m_pt[0] || busy4 !== (m_size(0) > 0)) begin
                n_errors++; $display("FAIL rand_out i=%0d got=%h/%h/%b exp=%h/%h/%b", i, pad_o4, pad_t4, busy4, m_po[0], m_pt[0], m_size(0) > 0);
            end
            n_checks++; if (if4.din_ready !== (m_size(0) < 2) || ws4 !== m_cnt[0]) begin
                n_errors++; $display("FAIL rand_ctl i=%0d got ready=%b words=%0d exp %b/%0d", i, if4.din_ready, ws4, m_size(0) < 2, m_cnt[0]);
            end
        end
        if4.din_valid = 1'b0;
        repeat (12) tick();
        n_checks++; if (busy4 !== 1'b0 || ws4 !== m_cnt[0]) begin
            n_errors++; $display("FAIL rand_drain got busy=%b words=%0d exp 0/%0d", busy4, ws4, m_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        if4.din = 16'h1234; if4.t_in = 4'h0; if4.din_valid = 1'b1;
        tick();
        if4.din = 16'h5678;
        tick();
        if4.din_valid = 1'b0;
        tick();  // first word now presenting bit 2, second word held
        n_checks++; if (if4.din_ready !== 1'b0 || m_size(0) != 2) begin
            n_errors++; $display("FAIL rmid_hold_full got ready=%b exp 0", if4.din_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        n_checks++; if (pad_o4 !== 4'h0 || pad_t4 !== 4'hF || busy4 !== 1'b0) begin
            n_errors++; $display("FAIL rmid_async got=%h/%h/%b exp 0/F/0", pad_o4, pad_t4, busy4);
        end
        n_checks++; if (if4.din_ready !== 1'b1 || ws4 !== 16'd0) begin
            n_errors++; $display("FAIL rmid_async_ctl got ready=%b words=%0d exp 1/0", if4.din_ready, ws4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        if4.din = 16'h9ABC; if4.t_in = 4'h3; if4.din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if4.din_valid = 1'b0;
            n_checks++; if (pad_o4 !== m_po[0] || pad_t4 !== m_pt[0]) begin
                n_errors++; $display("FAIL rmid_new cyc=%0d got=%h/%h exp=%h/%h", i+1, pad_o4, pad_t4, m_po[0], m_pt[0]);
            end
        end
        n_checks++; if (ws4 !== 16'd1 || busy4 !== 1'b0) begin
            n_errors++; $display("FAIL rmid_words got=%0d busy=%b exp 1/0", ws4, busy4);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        if1.din_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            if1.din = 4'(i);
            tick();
        end
        if1.din_valid = 1'b0;
        tick();
        n_checks++; if (ws1 !== 16'hFFFF || ws1 !== m_cnt[1]) begin
            n_errors++; $display("FAIL wrap_preload got=%h exp=FFFF", ws1);
        end
        if1.din = 4'hA; if1.din_valid = 1'b1;
        tick();
        if1.din_valid = 1'b0;
        tick();
        n_checks++; if (ws1 !== 16'h0000 || ws1 !== m_cnt[1]) begin
            n_errors++; $display("FAIL wrap_zero got=%h exp=0000", ws1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout got=no_finish exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gear1();
        test_tristate();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
